// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle between vga_timing_gen and its consumers
//
// Carries the pixel clock-enable, the raster counters, the undelayed
// sync/valid flags, the frame marker and the pipeline-aligned copies of
// sync/valid.
//   master: driven by vga_timing_gen
//   slave : observed by the address generator / DAC output stage
interface vga_timing_gen_if;
    logic       pix_tick;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       valid;
    logic       hsync;
    logic       vsync;
    logic       frame_start;
    logic       hsync_d;
    logic       vsync_d;
    logic       valid_d;

    modport master (
        output pix_tick, h_cnt, v_cnt, valid, hsync, vsync, frame_start,
               hsync_d, vsync_d, valid_d
    );

    modport slave (
        input  pix_tick, h_cnt, v_cnt, valid, hsync, vsync, frame_start,
               hsync_d, vsync_d, valid_d
    );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with aligned sync/valid delay line
//
// Divides clk by CLK_DIV into a pixel clock-enable and walks h_cnt/v_cnt
// over the full raster. Sync and valid flags are registered so they match
// the counters presented on the same cycle. A PIPE_DLY-tick shift register
// re-aligns the flags with downstream address/RAM latency.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   vif  : master side of vga_timing_gen_if (pix_tick, h_cnt, v_cnt, valid,
//          hsync, vsync, frame_start, hsync_d, vsync_d, valid_d)
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_DISP   = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_DISP   = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIPE_DLY = 2
) (
    input  logic               clk,
    input  logic               rst,
    vga_timing_gen_if.master   vif
);
    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

    localparam logic [3:0] DIV_MAX  = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISP);
    localparam logic [9:0] V_VIS    = 10'(V_DISP);
    localparam logic [9:0] HS_START = 10'(H_DISP + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_DISP + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_DISP + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_DISP + V_FP + V_SYNC);

    logic [3:0] div_cnt;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       hsync;
    logic       vsync;
    logic       valid;
    logic       pix_tick;
    logic       h_wrap;
    logic [9:0] h_nxt;
    logic [9:0] v_nxt;

    assign pix_tick = (div_cnt == DIV_MAX);
    assign h_wrap   = (h_cnt == H_MAX);
    assign h_nxt    = h_wrap ? 10'd0 : h_cnt + 10'd1;
    assign v_nxt    = !h_wrap ? v_cnt : ((v_cnt == V_MAX) ? 10'd0 : v_cnt + 10'd1);

    // Flags decode the *next* counter values so that, after the shared
    // tick edge, they describe the position now being presented. Reset
    // leaves (0,0) blanked; decoding takes over from the first tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= 4'd0;
            h_cnt   <= 10'd0;
            v_cnt   <= 10'd0;
            hsync   <= 1'b1;
            vsync   <= 1'b1;
            valid   <= 1'b0;
        end else begin
            div_cnt <= pix_tick ? 4'd0 : div_cnt + 4'd1;
            if (pix_tick) begin
                h_cnt <= h_nxt;
                v_cnt <= v_nxt;
                hsync <= !((h_nxt >= HS_START) && (h_nxt < HS_END));
                vsync <= !((v_nxt >= VS_START) && (v_nxt < VS_END));
                valid <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
            end
        end
    end

    assign vif.pix_tick    = pix_tick;
    assign vif.h_cnt       = h_cnt;
    assign vif.v_cnt       = v_cnt;
    assign vif.hsync       = hsync;
    assign vif.vsync       = vsync;
    assign vif.valid       = valid;
    assign vif.frame_start = pix_tick && h_wrap && (v_cnt == V_MAX);

    generate
        if (PIPE_DLY == 0) begin : g_no_dly
            assign vif.hsync_d = hsync;
            assign vif.vsync_d = vsync;
            assign vif.valid_d = valid;
        end else begin : g_dly
            // Each stage holds {hsync, vsync, valid}; stage 0 captures the
            // flags of the pixel just ending, so the last stage lags by
            // exactly PIPE_DLY ticks. Reset flushes every stage to idle.
            logic [PIPE_DLY-1:0][2:0] dly;

            always_ff @(posedge clk) begin
                if (rst) begin
                    dly <= {PIPE_DLY{3'b110}};
                end else if (pix_tick) begin
                    dly[0] <= {hsync, vsync, valid};
                    for (int i = 1; i < PIPE_DLY; i++) begin
                        dly[i] <= dly[i-1];
                    end
                end
            end

            assign vif.hsync_d = dly[PIPE_DLY-1][2];
            assign vif.vsync_d = dly[PIPE_DLY-1][1];
            assign vif.valid_d = dly[PIPE_DLY-1][0];
        end
    endgenerate
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480 @ 60 Hz VGA raster timing from the single system clock. It is the stage directly upstream of the frame-buffer address generator. It produces a pixel clock-enable, the horizontal/vertical counters `h_cnt`/`v_cnt` that drive address generation, and active-low sync and display-valid flags. A programmable pixel-tick delay line re-aligns sync/valid with the address-generator plus block-RAM read latency before they reach the DAC pins.

## Interface
Parameters:
- `CLK_DIV`, 4: system clocks per pixel (100 MHz -> 25 MHz); legal 2..16
- `H_DISP`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch (pixels)
- `H_SYNC`, 96: hsync pulse width (pixels)
- `H_BP`, 48: horizontal back porch; H_TOTAL = 800
- `V_DISP`, 480: visible lines
- `V_FP`, 10: vertical front porch (lines)
- `V_SYNC`, 2: vsync pulse width (lines)
- `V_BP`, 33: vertical back porch; V_TOTAL = 525
- `PIPE_DLY`, 2: delay of `*_d` outputs in pixel ticks; legal 0..7

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `pix_tick`  out  1  pixel clock-enable, one `clk` wide
- `h_cnt`  out  10  horizontal position 0..H_TOTAL-1
- `v_cnt`  out  10  vertical position 0..V_TOTAL-1
- `valid`  out  1  high when (`h_cnt`,`v_cnt`) is inside the visible area
- `hsync`  out  1  active-low horizontal sync, aligned to `h_cnt`
- `vsync`  out  1  active-low vertical sync, aligned to `v_cnt`
- `frame_start`  out  1  one-`clk` pulse in the last pixel of a frame
- `hsync_d`  out  1  `hsync` delayed PIPE_DLY pixel ticks
- `vsync_d`  out  1  `vsync` delayed PIPE_DLY pixel ticks
- `valid_d`  out  1  `valid` delayed PIPE_DLY pixel ticks

## Operation
- Divider: `div_cnt` counts 0..CLK_DIV-1 and wraps. `pix_tick` = (`div_cnt` == CLK_DIV-1), decoded from the register.
- Counters advance only on a `clk` edge where `pix_tick`=1.
  - `h_cnt` increments and wraps from H_TOTAL-1 to 0.
  - On that wrap, `v_cnt` increments and wraps from V_TOTAL-1 to 0.
- `hsync`, `vsync` and `valid` are registers. Each is loaded on the same edge as the counters, from the next counter values, so it always matches the `h_cnt`/`v_cnt` currently presented.
  - `hsync`=0 iff H_DISP+H_FP <= h < H_DISP+H_FP+H_SYNC, i.e. 656..751.
  - `vsync`=0 iff 490..491.
  - `valid`=1 iff h < 640 and v < 480.
- `frame_start`: combinational = `pix_tick` & (h==799) & (v==524). It is exactly one `clk` per frame.
- Delay line: PIPE_DLY-deep shift register of {`hsync`,`vsync`,`valid`}, shifted only when `pix_tick`=1. With PIPE_DLY=0 the `*_d` outputs equal the undelayed outputs combinationally.
- Arithmetic: all comparisons are unsigned 10-bit. Counters never take values at or above H_TOTAL/V_TOTAL.

## Timing
- Reset values on the edge where `rst`=1:
  - `div_cnt`=0, `h_cnt`=0, `v_cnt`=0
  - `hsync`=1, `vsync`=1, `valid`=0
  - all delay stages hold hsync=1, vsync=1, valid=0
  - therefore `hsync_d`=1, `vsync_d`=1, `valid_d`=0 and `pix_tick`=0
- The first pixel period after reset (0,0) is blanked (`valid`=0) by design. Normal decoding starts from (1,0).
- First `pix_tick` occurs in the CLK_DIV-th `clk` cycle after `rst` deasserts (cycle index CLK_DIV-1). After that, `pix_tick` recurs every CLK_DIV cycles with no jitter.
- Each (h,v) value is held for exactly CLK_DIV `clk` cycles.
- One line = 800 ticks. One frame = 420,000 ticks = 1,680,000 `clk` at CLK_DIV=4.
- Reset mid-frame takes effect on the next edge regardless of `pix_tick` phase. The divider phase restarts and the delay line is flushed to inactive.
- Simultaneous h wrap and v wrap (799,524 -> 0,0) happen on one edge. `frame_start` is high in the cycle before that edge.
- `*_d` outputs lag their sources by exactly PIPE_DLY×CLK_DIV `clk` cycles, measured from the edge where the source changed.

## Test plan
- Reset: hold `rst` 3 cycles mid-frame -> next cycle shows `h_cnt`=0, `v_cnt`=0, `hsync`=`vsync`=1, `valid`=0, `valid_d`=0, `pix_tick`=0. First `pix_tick` at post-reset cycle 3; (1,0) follows with `valid`=1.
- Tick spacing: run 40 cycles -> `pix_tick` high at cycles 3,7,11,…, and each `h_cnt` value is held for exactly 4 cycles.
- Horizontal sync: one line -> `hsync` low for exactly 96 ticks while h=656..751. `valid` is 1 for h=0..639 and 0 for 640..799 on visible lines.
- Line/frame wrap: run to h=799,v=524 -> `frame_start`=1 for one `clk`, then h=0,v=0.
  - h=799,v=10 -> next is h=0,v=11.
  - `vsync` is low only on v=490,491.
- Delay line with PIPE_DLY=2: `hsync` falls at h=656 -> `hsync_d` falls exactly 8 `clk` later. Repeat with PIPE_DLY=0 -> `*_d` are identical to the sources.
- Frame count: run 2 full frames -> exactly 2 `frame_start` pulses, 1,680,000 cycles apart.
